// File: rtl/mux_rr_nto1_if.sv
// Handshake bundle between N producer channels, the mux and its single consumer.
// The master drives the channel side plus out_ready; the slave is the mux itself.
interface mux_rr_nto1_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    localparam int SELW = $clog2(NCH);

    logic                mode;
    logic [SELW-1:0]     sel;
    logic [NCH-1:0]      in_valid;
    logic [NCH*DW-1:0]   in_data;
    logic [NCH-1:0]      in_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [SELW-1:0]     out_ch;
    logic                out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_rr_nto1.sv
// N-to-1 mux (fixed sel or round-robin) into one output register; 1-cycle latency, no bubble on back-to-back.
// Inputs stall only while a held word is refused by the consumer; MUX_RR_STATS_EN adds the out_cnt counter.
module mux_rr_nto1 #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef MUX_RR_STATS_EN
    output logic [15:0]  out_cnt,
`endif
    mux_rr_nto1_if.slave bus
);
    localparam int SELW = $clog2(NCH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   data_q;
    logic [SELW-1:0] ch_q;
    logic [SELW-1:0] rr_ptr_q;
    logic [SELW-1:0] rr_ptr_d;

    logic            load;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [DW-1:0]   gnt_dat;
    logic            xfer_in;

    assign load = (state_q == EMPTY) | bus.out_ready;

    // Round-robin search runs backwards so the last hit is the first channel after rr_ptr_q.
    always_comb begin : p_grant
        logic [SELW-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        if (!bus.mode) begin
            if ((int'(bus.sel) < NCH) && bus.in_valid[bus.sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = bus.sel;
            end
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                idx = SELW'((int'(rr_ptr_q) + k) % NCH);
                if (bus.in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
    end

    assign gnt_dat = bus.in_data[int'(gnt_idx)*DW +: DW];
    assign xfer_in = rst_n & load & gnt_vld;
    assign rr_ptr_d = (xfer_in && bus.mode) ? gnt_idx : rr_ptr_q;

    always_comb begin
        bus.in_ready = '0;
        if (xfer_in) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            ch_q     <= '0;
            rr_ptr_q <= SELW'(NCH - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        state_q <= FULL;
                        data_q  <= gnt_dat;
                        ch_q    <= gnt_idx;
                    end
                end
                FULL: begin
                    if (xfer_in) begin
                        data_q <= gnt_dat;
                        ch_q   <= gnt_idx;
                    end else if (bus.out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

`ifdef MUX_RR_STATS_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d = (bus.out_valid && bus.out_ready) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt = cnt_q;
`endif
endmodule
